// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light controller timing blocks.
package traffic_pkg;

  typedef enum logic [1:0] {INIT, IDLE, RUN} ptimer_state_t;

  localparam int BCD_MAX = 99;

endpackage

// File: rtl/phase_countdown_timer_bin2bcd99.sv
// Registered binary-to-two-digit BCD converter; saturates at 99 and flags overflow.
module bin2bcd99
  import traffic_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] bin,
  output logic [3:0]   tens,
  output logic [3:0]   units,
  output logic         ovf
);

  // Widen so 99 is representable even for narrow counts.
  localparam int XW = (W > 7) ? W : 7;

  logic [XW-1:0] bin_x;
  logic          over;
  logic [3:0]    tens_d, units_d;
  logic [3:0]    tens_q, units_q;

  always_comb begin
    bin_x   = XW'(bin);
    over    = bin_x > XW'(BCD_MAX);
    tens_d  = 4'd9;
    units_d = 4'd9;
    if (!over) begin
      tens_d  = 4'(bin_x / XW'(10));
      units_d = 4'(bin_x % XW'(10));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_q  <= '0;
      units_q <= '0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign tens  = tens_q;
  assign units = units_q;

  generate
    if (W > 6) begin : g_ovf
      logic ovf_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= over;
      end
      assign ovf = ovf_q;
    end else begin : g_no_ovf
      // A count of 6 bits or fewer can never exceed 99.
      assign ovf = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/phase_countdown_timer.sv
// Multi-phase countdown timer: per-phase durations, run/hold/restart control,
// phase-change pulse and registered BCD display digits.
module phase_countdown_timer
  import traffic_pkg::*;
#(
  parameter  int W    = 8,
  parameter  int NPH  = 3,
  localparam int PH_W = $clog2(NPH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pulse_1s,
  input  logic            enable,
  input  logic            hold,
  input  logic            restart,
  input  logic [NPH*W-1:0] dur,
  output logic [W-1:0]    count,
  output logic [PH_W-1:0] phase,
  output logic            phase_done,
  output logic [3:0]      bcd_tens,
  output logic [3:0]      bcd_units,
  output logic            disp_ovf
);

  ptimer_state_t         state_q, state_d;
  logic [W-1:0]          count_q, count_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic                  phase_done_q, phase_done_d;
  logic [NPH-1:0][W-1:0] dur_a;
  logic [PH_W-1:0]       phase_nxt;
  logic                  tick;

  assign dur_a     = dur;
  assign phase_nxt = (phase_q == PH_W'(NPH-1)) ? '0 : phase_q + 1'b1;
  assign tick      = pulse_1s && !hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= INIT;
      count_q      <= '0;
      phase_q      <= '0;
      phase_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      phase_q      <= phase_d;
      phase_done_q <= phase_done_d;
    end
  end

  // Ticks outside RUN, or on the same edge as a restart/disable, are dropped.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    phase_d      = phase_q;
    phase_done_d = 1'b0;
    unique case (state_q)
      INIT: begin
        count_d = dur_a[0];
        phase_d = '0;
        state_d = enable ? RUN : IDLE;
      end
      IDLE, RUN: begin
        if (restart) begin
          count_d = dur_a[0];
          phase_d = '0;
          state_d = enable ? RUN : IDLE;
        end else if (!enable) begin
          state_d = IDLE;
        end else if (state_q == IDLE) begin
          state_d = RUN;
        end else if (tick) begin
          if (count_q != '0) begin
            count_d = count_q - 1'b1;
          end else begin
            phase_d      = phase_nxt;
            count_d      = dur_a[phase_nxt];
            phase_done_d = 1'b1;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  assign count      = count_q;
  assign phase      = phase_q;
  assign phase_done = phase_done_q;

  bin2bcd99 #(.W(W)) u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .bin   (count_q),
    .tens  (bcd_tens),
    .units (bcd_units),
    .ovf   (disp_ovf)
  );

endmodule

// File: tb/tb_phase_countdown_timer.sv
// Directed bench for phase_countdown_timer with hand-computed expectations.
module tb_phase_countdown_timer;

  localparam int W    = 8;
  localparam int NPH  = 3;
  localparam int PH_W = $clog2(NPH);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pulse_1s, enable, hold, restart;
  logic [NPH*W-1:0] dur;
  logic [W-1:0]     count;
  logic [PH_W-1:0]  phase;
  logic             phase_done;
  logic [3:0]       bcd_tens, bcd_units;
  logic             disp_ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  phase_countdown_timer #(.W(W), .NPH(NPH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pulse_1s   (pulse_1s),
    .enable     (enable),
    .hold       (hold),
    .restart    (restart),
    .dur        (dur),
    .count      (count),
    .phase      (phase),
    .phase_done (phase_done),
    .bcd_tens   (bcd_tens),
    .bcd_units  (bcd_units),
    .disp_ovf   (disp_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle tick strobe; returns just after the edge that samples it.
  task automatic tick_now();
    pulse_1s = 1'b1;
    step();
    pulse_1s = 1'b0;
  endtask

  task automatic idle3();
    step(); step(); step();
  endtask

  task automatic chk_cp(input string tag, input int c, input int p, input int pd);
    chk({tag, "_count"}, 32'(count), 32'(c));
    chk({tag, "_phase"}, 32'(phase), 32'(p));
    chk({tag, "_pdone"}, 32'(phase_done), 32'(pd));
  endtask

  initial begin
    int cyc_c  [10] = '{4, 3, 2, 1, 0, 2, 1, 0, 0, 5};
    int cyc_p  [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 2, 0};
    int cyc_pd [10] = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 1};
    int mid_c  [9]  = '{3, 2, 1, 0, 2, 1, 0, 0, 9};
    int mid_p  [9]  = '{0, 0, 0, 0, 1, 1, 1, 2, 0};

    rst_n    = 1'b0;
    pulse_1s = 1'b0;
    enable   = 1'b1;
    hold     = 1'b0;
    restart  = 1'b0;
    dur      = {8'd0, 8'd2, 8'd5};

    #3;
    chk_cp("rst", 0, 0, 0);
    chk("rst_tens", 32'(bcd_tens), 0);
    chk("rst_units", 32'(bcd_units), 0);
    chk("rst_ovf", 32'(disp_ovf), 0);

    #9 rst_n = 1'b1;
    step();
    chk_cp("init", 5, 0, 0);
    chk("init_units_lag", 32'(bcd_units), 0);
    step();
    chk("init_units", 32'(bcd_units), 5);
    chk("init_tens", 32'(bcd_tens), 0);

    // Full cycle, one tick every 4th clk.
    for (int i = 0; i < 10; i++) begin
      tick_now();
      chk_cp($sformatf("cyc%0d", i), cyc_c[i], cyc_p[i], cyc_pd[i]);
      if (i == 0) chk("cyc_bcd_lag", 32'(bcd_units), 5);
      step();
      chk($sformatf("cyc%0d_pdone_clr", i), 32'(phase_done), 0);
      if (i == 0) chk("cyc_bcd_new", 32'(bcd_units), 4);
      step(); step();
    end

    // Hold, then disable, then release both.
    tick_now(); idle3();
    tick_now(); idle3();
    chk("pre_hold", 32'(count), 3);
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick_now(); idle3();
    end
    chk("hold_count", 32'(count), 3);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick_now(); idle3();
    end
    chk("disable_count", 32'(count), 3);
    enable = 1'b1;
    hold   = 1'b0;
    step();
    tick_now();
    chk_cp("release", 2, 0, 0);
    idle3();

    // Walk to phase 1, count 1.
    tick_now(); idle3();
    tick_now(); idle3();
    tick_now();
    chk_cp("to_p1", 2, 1, 1);
    idle3();
    tick_now(); idle3();
    chk_cp("p1_c1", 1, 1, 0);

    // Restart beats a simultaneous tick.
    restart  = 1'b1;
    pulse_1s = 1'b1;
    step();
    restart  = 1'b0;
    pulse_1s = 1'b0;
    chk_cp("restart", 5, 0, 0);
    idle3();

    // Mid-phase duration change only takes effect on the next load.
    tick_now(); idle3();
    chk("mid_start", 32'(count), 4);
    dur[7:0] = 8'd9;
    for (int i = 0; i < 9; i++) begin
      tick_now();
      chk($sformatf("mid%0d_count", i), 32'(count), 32'(mid_c[i]));
      chk($sformatf("mid%0d_phase", i), 32'(phase), 32'(mid_p[i]));
      idle3();
    end

    // Display saturation and overflow.
    dur[7:0] = 8'd150;
    restart  = 1'b1;
    step();
    restart  = 1'b0;
    chk("ovf_load", 32'(count), 150);
    step();
    chk("ovf_tens", 32'(bcd_tens), 9);
    chk("ovf_units", 32'(bcd_units), 9);
    chk("ovf_flag", 32'(disp_ovf), 1);

    pulse_1s = 1'b1;
    repeat (51) step();
    pulse_1s = 1'b0;
    step();
    chk("c99_count", 32'(count), 99);
    chk("c99_tens", 32'(bcd_tens), 9);
    chk("c99_units", 32'(bcd_units), 9);
    chk("c99_flag", 32'(disp_ovf), 0);

    pulse_1s = 1'b1;
    repeat (57) step();
    pulse_1s = 1'b0;
    step();
    chk("c42_count", 32'(count), 42);
    chk("c42_tens", 32'(bcd_tens), 4);
    chk("c42_units", 32'(bcd_units), 2);
    chk("c42_flag", 32'(disp_ovf), 0);

    // Asynchronous reset mid-run, between clock edges.
    #2 rst_n = 1'b0;
    #1;
    chk_cp("arst", 0, 0, 0);
    chk("arst_tens", 32'(bcd_tens), 0);
    chk("arst_units", 32'(bcd_units), 0);
    chk("arst_ovf", 32'(disp_ovf), 0);
    step();
    chk("arst_held", 32'(count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
